// File: rtl/mux_4.sv
// mux_4: 4-to-1 selector of N-bit channels. REG_OUT=1 gives a registered
// output with load enable, synchronous reset and a valid flag. REG_OUT=0
// gives a purely combinational output with valid tied high.
module mux_4 #(
  parameter int unsigned N       = 10,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   sel,
  input  logic [N-1:0] D0,
  input  logic [N-1:0] D1,
  input  logic [N-1:0] D2,
  input  logic [N-1:0] D3,
  output logic [N-1:0] Dout,
  output logic         valid
);

  logic [N-1:0] mux;

  // Channel selection. An unknown select drives all-X so it shows up in
  // simulation, and leaves synthesis free to treat it as don't-care.
  always_comb begin
    mux = 'x;
    case (sel)
      2'd0:    mux = D0;
      2'd1:    mux = D1;
      2'd2:    mux = D2;
      2'd3:    mux = D3;
      default: mux = 'x;
    endcase
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [N-1:0] dout_q;
      logic         valid_q;

      // Output register: reset clears data and valid, otherwise load on en.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else if (en) begin
          dout_q  <= mux;
          valid_q <= 1'b1;
        end
      end

      assign Dout  = dout_q;
      assign valid = valid_q;
    end else begin : g_comb
      // clk, rst and en are intentionally unused in this configuration.
      logic unused;
      assign unused = &{1'b0, clk, rst, en};
      assign Dout   = mux;
      assign valid  = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_mux_4.sv
// tb_mux_4: checks a registered (REG_OUT=1) and a combinational (REG_OUT=0)
// instance side by side, sharing the same inputs.
module tb_mux_4;

  localparam int unsigned N = 10;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   sel;
  logic [N-1:0] d0, d1, d2, d3;
  logic [N-1:0] dout_r, dout_c;
  logic         valid_r, valid_c;

  int unsigned total;
  int unsigned passed;

  mux_4 #(.N(N), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .D0(d0), .D1(d1), .D2(d2), .D3(d3),
    .Dout(dout_r), .valid(valid_r)
  );

  mux_4 #(.N(N), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .D0(d0), .D1(d1), .D2(d2), .D3(d3),
    .Dout(dout_c), .valid(valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         en;
    logic [1:0]   sel;
    logic [N-1:0] d0, d1, d2, d3;
    logic [N-1:0] exp_dout;
    logic         exp_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic e, logic [1:0] s,
                              logic [N-1:0] a, logic [N-1:0] b,
                              logic [N-1:0] c, logic [N-1:0] d,
                              logic [N-1:0] xd, logic xv);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.sel = s;
    v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d;
    v.exp_dout = xd; v.exp_valid = xv;
    return v;
  endfunction

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference selection written as array indexing.
  function automatic logic [N-1:0] pick(logic [1:0] s, logic [N-1:0] a,
                                        logic [N-1:0] b, logic [N-1:0] c,
                                        logic [N-1:0] d);
    logic [N-1:0] ch[4];
    ch[0] = a; ch[1] = b; ch[2] = c; ch[3] = d;
    return ch[s];
  endfunction

  task automatic apply(logic r, logic e, logic [1:0] s, logic [N-1:0] a,
                       logic [N-1:0] b, logic [N-1:0] c, logic [N-1:0] d);
    rst = r; en = e; sel = s; d0 = a; d1 = b; d2 = c; d3 = d;
  endtask

  logic [N-1:0] m_dout;
  logic         m_valid;
  logic [N-1:0] dv[4];
  logic [N-1:0] held;

  initial begin
    total = 0; passed = 0;
    apply(1'b0, 1'b0, 2'd0, '0, '0, '0, '0);

    // Reset for two cycles, then first load; sequential stepping; hold; leakage.
    vecs.push_back(mk("rst_c1",   1, 1, 0, 10'h3FF, 0, 0, 0, 10'h000, 0));
    vecs.push_back(mk("rst_c2",   1, 1, 0, 10'h3FF, 0, 0, 0, 10'h000, 0));
    vecs.push_back(mk("rel_load", 0, 1, 0, 10'h3FF, 0, 0, 0, 10'h3FF, 1));
    vecs.push_back(mk("step0",    0, 1, 0, 0, 1, 2, 3, 10'd0, 1));
    vecs.push_back(mk("step1",    0, 1, 1, 0, 1, 2, 3, 10'd1, 1));
    vecs.push_back(mk("step2",    0, 1, 2, 0, 1, 2, 3, 10'd2, 1));
    vecs.push_back(mk("step3",    0, 1, 3, 0, 1, 2, 3, 10'd3, 1));
    vecs.push_back(mk("load2",    0, 1, 2, 0, 1, 2, 3, 10'd2, 1));
    vecs.push_back(mk("hold_a",   0, 0, 3, 0, 1, 10'h155, 3, 10'd2, 1));
    vecs.push_back(mk("hold_b",   0, 0, 3, 0, 1, 10'h155, 3, 10'd2, 1));
    vecs.push_back(mk("reen",     0, 1, 3, 0, 1, 10'h155, 3, 10'd3, 1));
    vecs.push_back(mk("ones_s0",  0, 1, 0, 10'h3FF, 0, 0, 0, 10'h3FF, 1));
    vecs.push_back(mk("ones_s1",  0, 1, 1, 0, 10'h3FF, 0, 0, 10'h3FF, 1));
    vecs.push_back(mk("ones_s2",  0, 1, 2, 0, 0, 10'h3FF, 0, 10'h3FF, 1));
    vecs.push_back(mk("ones_s3",  0, 1, 3, 0, 0, 0, 10'h3FF, 10'h3FF, 1));
    vecs.push_back(mk("zero_s0",  0, 1, 0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000, 1));
    vecs.push_back(mk("zero_s1",  0, 1, 1, 10'h3FF, 0, 10'h3FF, 10'h3FF, 10'h000, 1));
    vecs.push_back(mk("zero_s2",  0, 1, 2, 10'h3FF, 10'h3FF, 0, 10'h3FF, 10'h000, 1));
    vecs.push_back(mk("zero_s3",  0, 1, 3, 10'h3FF, 10'h3FF, 10'h3FF, 0, 10'h000, 1));
    vecs.push_back(mk("rst_ovr",  1, 1, 1, 0, 10'h2AA, 0, 0, 10'h000, 0));
    vecs.push_back(mk("en0_post", 0, 0, 1, 0, 10'h2AA, 0, 0, 10'h000, 0));
    vecs.push_back(mk("load_2AA", 0, 1, 1, 0, 10'h2AA, 0, 0, 10'h2AA, 1));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].sel,
            vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
      #1;
      check({vecs[i].name, "_comb"},
            dout_c, pick(vecs[i].sel, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3));
      @(posedge clk); #1;
      check(vecs[i].name, dout_r, vecs[i].exp_dout);
      check({vecs[i].name, "_valid"}, {{(N-1){1'b0}}, valid_r},
            {{(N-1){1'b0}}, vecs[i].exp_valid});
    end

    // rst raised between edges has no immediate effect; it acts at the edge.
    held = dout_r;
    #2 rst = 1'b1;
    #1 check("rst_midcycle_dout", dout_r, held);
    check("rst_midcycle_valid", {{(N-1){1'b0}}, valid_r}, {{(N-1){1'b0}}, 1'b1});
    @(posedge clk); #1;
    check("rst_at_edge", dout_r, '0);

    // Combinational instance: mid-cycle sel change, rst ignored, valid high.
    apply(1'b0, 1'b1, 2'd0, 10'd0, 10'd1, 10'd2, 10'd3);
    @(posedge clk); #2;
    check("comb_sel0", dout_c, 10'd0);
    sel = 2'd3;
    #1 check("comb_sel3_noedge", dout_c, 10'd3);
    rst = 1'b1;
    #1 check("comb_rst_ignored", dout_c, 10'd3);
    @(posedge clk); #1;
    check("comb_rst_edge", dout_c, 10'd3);
    check("comb_valid", {{(N-1){1'b0}}, valid_c}, {{(N-1){1'b0}}, 1'b1});
    rst = 1'b0;

    // Free-running sel counter through wraps with a one-cycle reset pulse.
    dv[0] = 10'd11; dv[1] = 10'd22; dv[2] = 10'd33; dv[3] = 10'd44;
    for (int i = 0; i < 12; i++) begin
      apply((i == 6), 1'b1, 2'(i % 4), dv[0], dv[1], dv[2], dv[3]);
      @(posedge clk); #1;
      check($sformatf("cnt_%0d", i), dout_r, (i == 6) ? '0 : dv[i % 4]);
      check($sformatf("cnt_valid_%0d", i), {{(N-1){1'b0}}, valid_r},
            {{(N-1){1'b0}}, (i != 6)});
    end

    // Randomized traffic against a behavioural model.
    m_dout = dout_r;
    m_valid = valid_r;
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)),
            N'($urandom), N'($urandom), N'($urandom), N'($urandom));
      #1;
      check($sformatf("rnd_comb_%0d", i), dout_c, pick(sel, d0, d1, d2, d3));
      if (rst) begin
        m_dout = '0; m_valid = 1'b0;
      end else if (en) begin
        m_dout = pick(sel, d0, d1, d2, d3); m_valid = 1'b1;
      end
      @(posedge clk); #1;
      check($sformatf("rnd_reg_%0d", i), dout_r, m_dout);
      check($sformatf("rnd_valid_%0d", i), {{(N-1){1'b0}}, valid_r},
            {{(N-1){1'b0}}, m_valid});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_4.md
MUX_4 -- requirements
Module: mux_4

Interface
REQ-001 Parameter N, default 10: data width in bits of every data input and of Dout; legal range 1..64.
REQ-002 Parameter REG_OUT, default 1: 1 = registered output (1-cycle latency); 0 = combinational output (0-cycle latency).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  load enable for the output register; ignored when REG_OUT=0.
REQ-006 sel  input  2  select code: 0=D0, 1=D1, 2=D2, 3=D3.
REQ-007 D0  input  N  data channel 0.
REQ-008 D1  input  N  data channel 1.
REQ-009 D2  input  N  data channel 2.
REQ-010 D3  input  N  data channel 3.
REQ-011 Dout  output  N  selected data.
REQ-012 valid  output  1  high when Dout holds a value loaded since the last reset; constant 1 when REG_OUT=0.

Function
REQ-013 Selection: mux = D0 when sel=0, D1 when sel=1, D2 when sel=2, D3 when sel=3; full-width copy, no truncation, no sign or zero extension.
REQ-014 sel containing X or Z: mux output is all-X in simulation; synthesis is free to treat this as don't-care; no latch is inferred.
REQ-015 REG_OUT=1, en=1, rst=0: on the rising edge, Dout <= mux of sel and D0..D3 sampled at that edge, and valid <= 1.
REQ-016 REG_OUT=1, en=0, rst=0: Dout and valid hold their current values; changes on sel or data are ignored.
REQ-017 REG_OUT=0: Dout = mux combinationally; a sel or data change propagates with no clock edge; clk, rst and en have no effect on Dout.
REQ-018 Latency with REG_OUT=1 is exactly one clock: sel or data presented before edge k appears on Dout after edge k.
REQ-019 Back-to-back operation: a new sel value every cycle with en=1 yields a new Dout every cycle; there are no bubbles and no stall.
REQ-020 sel wrap-around: a 2-bit counter moving 3 -> 0 selects D3 and then D0; no other code exists.
REQ-021 Simultaneous changes of data and sel in one cycle: the value registered is the mux of both new values.

Reset
REQ-022 rst is sampled only at the rising edge of clk; asserting rst between edges has no immediate effect.
REQ-023 REG_OUT=1, rst=1 at an edge: Dout <= 0 (all N bits) and valid <= 0; rst overrides en.
REQ-024 rst held for several cycles: Dout stays 0 and valid stays 0 throughout.
REQ-025 First edge with rst=0 and en=1 after reset: loads the mux value and sets valid=1.
REQ-026 Reset during streaming: the value in flight is discarded; Dout=0 after the reset edge.
REQ-027 REG_OUT=0: rst has no effect on Dout; valid remains 1.

Verification
REQ-028 N=10, REG_OUT=1, D0=0, D1=1, D2=2, D3=3, en=1, sel stepping 0,1,2,3 one per cycle -> Dout = 0,1,2,3 on the following cycles, valid=1.
REQ-029 rst=1 for 2 cycles with D0=0x3FF and sel=0 -> Dout=0 and valid=0; first edge after release -> Dout=0x3FF, valid=1.
REQ-030 Load Dout=2 (sel=2), then drive en=0 and change sel to 3 and D2 to 0x155 -> Dout stays 2; re-assert en -> Dout=3.
REQ-031 Drive all-ones on the selected channel and all-zeros on the others, for each sel -> Dout=0x3FF only from the chosen channel; confirms no cross-channel leakage and a full-width path.
REQ-032 REG_OUT=0: sel changes 0 -> 3 mid-cycle with D0=0, D3=3 -> Dout changes 0 -> 3 without a clock edge; asserting rst leaves Dout unchanged.
REQ-033 Continuous sel counter with en=1 through wrap 3 -> 0 while rst pulses for 1 cycle -> Dout=0 on the cycle after the reset edge, then resumes following sel with 1-cycle latency.
